mem_port_arbiter: RTL and testbench

Sequencing controller for the core's single shared memory port. It arbitrates between instruction fetch (requester 0) and the load/store unit (requester 1), and registers the winner's command onto the port. It drives the select of the registered 2:1 port mux and returns each response to the requester that issued it. A bounded wait ends any transaction the memory never acknowledges.

---
 rtl/riscv_mem_pkg.sv | 26 ++
 rtl/mem_port_arbiter_arb2_rr.sv | 32 +++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// ============================================================================
// Module      : riscv_mem_pkg
// Description : Shared types and constants for the memory-port sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_mem_pkg;

  // Width of the memory port address and data buses
  localparam int XLEN = 32;

  // Requester indices; also the encoding of the port mux select
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LSU   = 1'b1;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_arb2_rr.sv
// ============================================================================
// Module      : arb2_rr
// Description : Two-way round-robin pick. On a tie the requester that was
//               not served last wins; a lone requester always wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb2_rr
  import riscv_mem_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_owner_i,
  output logic winner_o,
  output logic valid_o
);

  // Pick the winner from the current requests and the previous owner
  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = REQ_FETCH;
    if (req0_i && req1_i) begin
      winner_o = ~last_owner_i;
    end else if (req1_i) begin
      winner_o = REQ_LSU;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Sequencer for the single shared memory port. Arbitrates
//               between fetch and LSU, registers the winning command, waits
//               for the memory ack (bounded by MAX_WAIT) and routes the
//               response back to the requester that issued it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic            clk_i,
  input  logic            res_i,
  input  logic            req0_i,
  input  logic            req1_i,
  input  logic [XLEN-1:0] addr0_i,
  input  logic [XLEN-1:0] addr1_i,
  input  logic [XLEN-1:0] wdata0_i,
  input  logic [XLEN-1:0] wdata1_i,
  input  logic            we0_i,
  input  logic            we1_i,
  output logic            gnt0_o,
  output logic            gnt1_o,
  output logic            rvalid0_o,
  output logic            rvalid1_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic            mem_we_o,
  output logic            mem_sel_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int            CW    = $clog2(MAX_WAIT + 1);
  // Counter value seen on the MAX_WAIT-th ISSUE cycle (counter starts at 0)
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            last_q, last_d;
  logic            owner_q, owner_d;
  logic            sel_q, sel_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic            rv0_q, rv0_d;
  logic            rv1_q, rv1_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            win;
  logic            win_valid;
  logic            accept;

  arb2_rr u_arb (
    .req0_i       (req0_i),
    .req1_i       (req1_i),
    .last_owner_i (last_q),
    .winner_o     (win),
    .valid_o      (win_valid)
  );

  // Offer a grant to the arbitration winner only while idle and out of reset
  always_comb begin
    gnt0_o = (state_q == IDLE) && !res_i && win_valid && (win == REQ_FETCH);
    gnt1_o = (state_q == IDLE) && !res_i && win_valid && (win == REQ_LSU);
    accept = gnt0_o | gnt1_o;
  end

  // Next-state and next-register values for the sequencer
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    last_d  = last_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = (win == REQ_LSU) ? addr1_i  : addr0_i;
          wdata_d = (win == REQ_LSU) ? wdata1_i : wdata0_i;
          we_d    = (win == REQ_LSU) ? we1_i    : we0_i;
          sel_d   = win;
          owner_d = win;
          last_d  = win;
          wait_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wait_d = wait_q + CW'(1);
        // An ack on the limit cycle takes priority over the timeout
        if (mem_ack_i) begin
          rdata_d = mem_rdata_i;
          err_d   = 1'b0;
          rv0_d   = (owner_q == REQ_FETCH);
          rv1_d   = (owner_q == REQ_LSU);
          state_d = RESP;
        end else if (wait_q == LIMIT) begin
          rdata_d = '0;
          err_d   = 1'b1;
          rv0_d   = (owner_q == REQ_FETCH);
          rv1_d   = (owner_q == REQ_LSU);
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
      last_q  <= REQ_FETCH;
      owner_q <= REQ_FETCH;
      sel_q   <= REQ_FETCH;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  // Port-facing outputs come straight from registers
  always_comb begin
    mem_req_o   = (state_q == ISSUE);
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    mem_we_o    = we_q;
    mem_sel_o   = sel_q;
    rdata_o     = rdata_q;
    err_o       = err_q;
    rvalid0_o   = rv0_q;
    rvalid1_o   = rv1_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed scenarios
//               with literal expectations, then randomized traffic checked
//               every cycle against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        res;
  logic        req0, req1, we0, we1, mem_ack;
  logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
  logic        gnt0, gnt1, rvalid0, rvalid1, err, mem_req, mem_we, mem_sel;
  logic [31:0] rdata, mem_addr, mem_wdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.MAX_WAIT(MW)) dut (
    .clk_i       (clk),
    .res_i       (res),
    .req0_i      (req0),
    .req1_i      (req1),
    .addr0_i     (addr0),
    .addr1_i     (addr1),
    .wdata0_i    (wdata0),
    .wdata1_i    (wdata1),
    .we0_i       (we0),
    .we1_i       (we1),
    .gnt0_o      (gnt0),
    .gnt1_o      (gnt1),
    .rvalid0_o   (rvalid0),
    .rvalid1_o   (rvalid1),
    .rdata_o     (rdata),
    .err_o       (err),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_sel_o   (mem_sel),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level reference: an open command, a pending response, and
  // the owner history used by the round-robin rule.
  logic        m_txn, m_resp, m_owner, m_last, m_err, m_we, m_sel;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          m_waited;
  logic        e_g0, e_g1, e_win, e_idle;

  initial begin
    m_txn = 0; m_resp = 0; m_owner = 0; m_last = 0; m_err = 0;
    m_we = 0; m_sel = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_waited = 0;
  end

  // Compare DUT against the model mid-cycle, then advance the model by one edge
  always @(negedge clk) begin
    e_idle = !m_txn && !m_resp;
    e_win  = (req0 && req1) ? !m_last : req1;
    e_g0   = e_idle && !res && req0 && !e_win;
    e_g1   = e_idle && !res && req1 && e_win;
    chk("m_gnt0", {31'd0, gnt0}, {31'd0, e_g0});
    chk("m_gnt1", {31'd0, gnt1}, {31'd0, e_g1});
    chk("m_mem_req", {31'd0, mem_req}, {31'd0, m_txn});
    chk("m_mem_sel", {31'd0, mem_sel}, {31'd0, m_sel});
    chk("m_mem_we", {31'd0, mem_we}, {31'd0, m_we});
    chk("m_mem_addr", mem_addr, m_addr);
    if (m_we) chk("m_mem_wdata", mem_wdata, m_wdata);
    chk("m_rvalid0", {31'd0, rvalid0}, {31'd0, m_resp && !m_owner});
    chk("m_rvalid1", {31'd0, rvalid1}, {31'd0, m_resp && m_owner});
    if (m_resp) begin
      chk("m_rdata", rdata, m_rdata);
      chk("m_err", {31'd0, err}, {31'd0, m_err});
    end

    if (res) begin
      m_txn = 0; m_resp = 0; m_last = 0; m_sel = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_err = 0; m_owner = 0;
    end else if (e_g0 || e_g1) begin
      m_txn    = 1;
      m_owner  = e_g1;
      m_last   = e_g1;
      m_sel    = e_g1;
      m_addr   = e_g1 ? addr1  : addr0;
      m_wdata  = e_g1 ? wdata1 : wdata0;
      m_we     = e_g1 ? we1    : we0;
      m_waited = 0;
    end else if (m_txn) begin
      m_waited++;
      if (mem_ack) begin
        m_txn = 0; m_resp = 1; m_rdata = mem_rdata; m_err = 0;
      end else if (m_waited == MW) begin
        m_txn = 0; m_resp = 1; m_rdata = 0; m_err = 1;
      end
    end else if (m_resp) begin
      m_resp = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    res = 1; req0 = 1; req1 = 1; we0 = 0; we1 = 0; mem_ack = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mem_rdata = 0;

    // Reset state, with both requests raised to show grants are gated
    neg();
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    cyc();
    neg();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_sel", {31'd0, mem_sel}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    cyc();
    res = 0; req0 = 0; req1 = 0;

    // Single fetch, ack on the second ISSUE cycle
    req0 = 1; addr0 = 32'h0000_0100;
    neg();
    chk("f_gnt0", {31'd0, gnt0}, 32'd1);
    chk("f_gnt1", {31'd0, gnt1}, 32'd0);
    cyc(); req0 = 0;
    neg();
    chk("f_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_sel", {31'd0, mem_sel}, 32'd0);
    cyc(); mem_ack = 1; mem_rdata = 32'h1234_5678;
    cyc(); mem_ack = 0; mem_rdata = 0;
    neg();
    chk("f_rvalid0", {31'd0, rvalid0}, 32'd1);
    chk("f_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("f_rdata", rdata, 32'h1234_5678);
    chk("f_err", {31'd0, err}, 32'd0);
    cyc();

    // Contention: held ties alternate LSU, fetch, LSU, fetch every 3 cycles
    req0 = 1; req1 = 1; addr0 = 32'hA0; addr1 = 32'hB0;
    for (int k = 0; k < 4; k++) begin
      neg();
      chk("c_gnt1", {31'd0, gnt1}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("c_gnt0", {31'd0, gnt0}, (k % 2 == 0) ? 32'd0 : 32'd1);
      cyc(); mem_ack = 1;
      neg();
      chk("c_mem_sel", {31'd0, mem_sel}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("c_mem_addr", mem_addr, (k % 2 == 0) ? 32'hB0 : 32'hA0);
      cyc(); mem_ack = 0;
      cyc();
    end
    req0 = 0; req1 = 0;

    // LSU store held stable while waiting
    req1 = 1; we1 = 1; wdata1 = 32'hDEAD_BEEF; addr1 = 32'h200;
    neg();
    chk("s_gnt1", {31'd0, gnt1}, 32'd1);
    cyc(); req1 = 0; we1 = 0; wdata1 = 0;
    for (int i = 0; i < 2; i++) begin
      neg();
      chk("s_mem_req", {31'd0, mem_req}, 32'd1);
      chk("s_mem_we", {31'd0, mem_we}, 32'd1);
      chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      cyc();
    end
    mem_ack = 1; mem_rdata = 32'h55;
    cyc(); mem_ack = 0;
    neg();
    chk("s_rvalid1", {31'd0, rvalid1}, 32'd1);
    chk("s_rvalid0", {31'd0, rvalid0}, 32'd0);
    cyc();

    // Timeout with no ack, then a stray ack in IDLE
    req0 = 1; addr0 = 32'h300;
    neg();
    chk("t_gnt0", {31'd0, gnt0}, 32'd1);
    cyc(); req0 = 0;
    for (int i = 1; i <= MW; i++) begin
      neg();
      chk("t_mem_req", {31'd0, mem_req}, 32'd1);
      cyc();
    end
    neg();
    chk("t_rvalid0", {31'd0, rvalid0}, 32'd1);
    chk("t_err", {31'd0, err}, 32'd1);
    chk("t_rdata", rdata, 32'd0);
    chk("t_mem_req_end", {31'd0, mem_req}, 32'd0);
    cyc(); mem_ack = 1; mem_rdata = 32'h7777;
    neg();
    chk("t_idle_req", {31'd0, mem_req}, 32'd0);
    cyc(); mem_ack = 0;
    neg();
    chk("t_stray_rv0", {31'd0, rvalid0}, 32'd0);
    chk("t_stray_rv1", {31'd0, rvalid1}, 32'd0);
    cyc();

    // Ack on the last allowed ISSUE cycle wins over the timeout
    req0 = 1; addr0 = 32'h400;
    cyc(); req0 = 0;
    cyc(); cyc(); cyc();
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    neg();
    chk("l_mem_req", {31'd0, mem_req}, 32'd1);
    cyc(); mem_ack = 0; mem_rdata = 0;
    neg();
    chk("l_rvalid0", {31'd0, rvalid0}, 32'd1);
    chk("l_err", {31'd0, err}, 32'd0);
    chk("l_rdata", rdata, 32'hCAFE_F00D);
    cyc();

    // Reset mid-ISSUE after an LSU accept: dropped, and LSU wins the next tie
    req1 = 1; addr1 = 32'h500;
    neg();
    chk("r_gnt1", {31'd0, gnt1}, 32'd1);
    cyc(); req1 = 0;
    neg();
    chk("r_mem_sel_pre", {31'd0, mem_sel}, 32'd1);
    cyc(); res = 1;
    cyc(); res = 0;
    neg();
    chk("r_mem_req", {31'd0, mem_req}, 32'd0);
    chk("r_mem_sel", {31'd0, mem_sel}, 32'd0);
    chk("r_mem_addr", mem_addr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      neg();
      chk("r_rvalid0", {31'd0, rvalid0}, 32'd0);
      chk("r_rvalid1", {31'd0, rvalid1}, 32'd0);
    end
    cyc(); req0 = 1; req1 = 1;
    neg();
    chk("r_tie_gnt1", {31'd0, gnt1}, 32'd1);
    chk("r_tie_gnt0", {31'd0, gnt0}, 32'd0);
    cyc(); req0 = 0; req1 = 0; mem_ack = 1;
    cyc(); mem_ack = 0;
    cyc(); cyc();

    // Randomized traffic checked by the model
    for (int n = 0; n < 3000; n++) begin
      cyc();
      res       = ($urandom_range(99) == 0);
      req0      = $urandom_range(1);
      req1      = $urandom_range(1);
      we0       = $urandom_range(1);
      we1       = $urandom_range(1);
      addr0     = $urandom;
      addr1     = $urandom;
      wdata0    = $urandom;
      wdata1    = $urandom;
      mem_ack   = ($urandom_range(2) == 0);
      mem_rdata = $urandom;
    end
    cyc();
    res = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; mem_ack = 0;
    repeat (10) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
